// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state, opcode, ALU and mux-select encodings for the multicycle control path
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
  } alu_ctrl_t;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: instruction fields and status in, datapath control strobes and selects out
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero_flg;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_instr;
  modport master (
    input  op, funct3, funct7b5, zero_flg, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, instr_done, illegal_instr
  );
  modport slave (
    output op, funct3, funct7b5, zero_flg, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// alu_decoder: maps ALUOp plus instruction function bits onto the shared ALU operation
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output alu_ctrl_t  alu_control
);
  always_comb begin
    alu_control = ALU_ADD;
    if (alu_op == ALUOP_SUB)
      alu_control = ALU_SUB;
    else if (alu_op == ALUOP_FUNCT)
      case (funct3)
        3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control = ALU_SLT;
        3'b110:  alu_control = ALU_OR;
        3'b111:  alu_control = ALU_AND;
        default: alu_control = ALU_ADD;
      endcase
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: per-instruction state sequencer for the shared-memory RV32I subset datapath
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input logic clk,
  input logic rst_n,
  multicycle_ctrl_fsm_if.master bus
);
  state_t state, state_nxt;
  alu_ctrl_t alu_ctl;
  logic [1:0] alu_op, src_a, src_b, result_src;
  logic adr_src, branch, pc_update, ir_wr, mem_wr, reg_wr, done, illegal, legal;
  assign legal = bus.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (bus.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_FETCH;
        endcase
      S_MEMADR:   state_nxt = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_nxt = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_JAL:      state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end
  always_comb begin
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRC_A_PC;
    src_b      = SRC_B_RS2;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        result_src = RES_ALURESULT;
        src_b      = SRC_B_FOUR;
        ir_wr      = bus.mem_ready;
        pc_update  = bus.mem_ready;
      end
      S_DECODE: begin
        src_a   = SRC_A_OLDPC;
        src_b   = SRC_B_IMM;
        illegal = !legal;
        done    = !legal;
      end
      S_MEMADR: begin
        src_a = SRC_A_RS1;
        src_b = SRC_B_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_wr     = 1'b1;
        done       = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_wr  = 1'b1;
        done    = bus.mem_ready;
      end
      S_EXECR: begin
        src_a  = SRC_A_RS1;
        alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_IMM;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_wr = 1'b1;
        done   = 1'b1;
      end
      S_BEQ: begin
        src_a  = SRC_A_RS1;
        alu_op = ALUOP_SUB;
        branch = 1'b1;
        done   = 1'b1;
      end
      S_JAL: begin
        src_a     = SRC_A_OLDPC;
        src_b     = SRC_B_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end
  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (bus.funct3),
    .op5        (bus.op[5]),
    .funct7b5   (bus.funct7b5),
    .alu_control(alu_ctl)
  );
  // strobes are gated by rst_n so nothing fires while reset is held, even mid-instruction
  assign bus.pc_write      = rst_n & ((branch & bus.zero_flg) | pc_update);
  assign bus.ir_write      = rst_n & ir_wr;
  assign bus.mem_write     = rst_n & mem_wr;
  assign bus.reg_write     = rst_n & reg_wr;
  assign bus.instr_done    = rst_n & done;
  assign bus.illegal_instr = rst_n & illegal;
  assign bus.adr_src       = adr_src;
  assign bus.result_src    = result_src;
  assign bus.alu_src_a     = src_a;
  assign bus.alu_src_b     = src_b;
  assign bus.alu_control   = alu_ctl;
  assign bus.imm_src       = imm_src_of(bus.op);
endmodule
